// File: rtl/contador_pkg.sv
// ============================================================================
// Module   : contador_pkg
// Brief    : Shared mode codes, FSM encoding and step constant for the
//            contador counter monitor and its reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package contador_pkg;

    localparam logic [1:0] MODE_UP    = 2'b00;
    localparam logic [1:0] MODE_DOWN  = 2'b01;
    localparam logic [1:0] MODE_DOWN3 = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    localparam int DEC_STEP = 3;

    typedef enum logic [1:0] {
        ST_WAIT_SYNC = 2'd0,
        ST_CHECK     = 2'd1,
        ST_RESYNC    = 2'd2
    } state_t;

endpackage : contador_pkg

`default_nettype wire

// File: rtl/contador_ref_model.sv
// ============================================================================
// Module   : contador_ref_model
// Brief    : Combinational next-value predictor for the contador counter:
//            one shared adder plus an output mux.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module contador_ref_model
    import contador_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_enable,
    input  logic [1:0]       i_mode,
    input  logic [3:0]       i_d,
    output logic [WIDTH-1:0] o_q,
    output logic             o_rco,
    output logic             o_load
);

    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_sum;

    // Down steps add the two's complement; the carry out is then the
    // inverse of the borrow, so rco falls out of the same adder.
    always_comb begin
        w_addend = WIDTH'(0) - WIDTH'(DEC_STEP);
        case (i_mode)
            MODE_UP:   w_addend = WIDTH'(1);
            MODE_DOWN: w_addend = '1;
            default:   w_addend = WIDTH'(0) - WIDTH'(DEC_STEP);
        endcase
    end

    assign w_sum = {1'b0, i_q} + {1'b0, w_addend};

    always_comb begin
        o_q    = i_q;
        o_rco  = 1'b0;
        o_load = 1'b0;
        if (i_enable) begin
            case (i_mode)
                MODE_UP: begin
                    o_q   = w_sum[WIDTH-1:0];
                    o_rco = w_sum[WIDTH];
                end
                MODE_DOWN, MODE_DOWN3: begin
                    o_q   = w_sum[WIDTH-1:0];
                    o_rco = ~w_sum[WIDTH];
                end
                default: begin
                    o_q    = {{(WIDTH-4){1'b0}}, i_d};
                    o_load = 1'b1;
                end
            endcase
        end
    end

endmodule : contador_ref_model

`default_nettype wire

// File: rtl/contador_monitor.sv
// ============================================================================
// Module   : contador_monitor
// Brief    : On-chip checker for the contador counter: predicts Q/rco/load,
//            flags mismatches, counts errors and rollover events.
//            Optional first-error capture: CONTADOR_MONITOR_FIRST_ERR_CAPTURE_EN
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module contador_monitor
    import contador_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [3:0]       D,
    input  logic             load,
    input  logic             rco,
    input  logic [0:WIDTH-1] Q,
`ifdef CONTADOR_MONITOR_FIRST_ERR_CAPTURE_EN
    output logic [WIDTH-1:0] first_err_exp,
    output logic [WIDTH-1:0] first_err_got,
    output logic [31:0]      first_err_cycle,
`endif
    output logic             synced,
    output logic             err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] rco_count
);

    state_t           r_state;
    logic [WIDTH-1:0] r_exp_q;
    logic             r_exp_rco;
    logic             r_exp_load;
    logic             r_exp_valid;
    logic             r_err;
    logic             r_err_sticky;
    logic [CNT_W-1:0] r_err_count;
    logic [CNT_W-1:0] r_rco_count;

    logic [WIDTH-1:0] w_q_obs;
    logic [WIDTH-1:0] w_pred_base;
    logic [WIDTH-1:0] w_pred_q;
    logic             w_pred_rco;
    logic             w_pred_load;
    logic             w_mismatch;

    assign w_q_obs = Q;

    // Outside CHECK the prediction is seeded from the observed Q so the
    // model realigns after reset release and after every reported error.
    assign w_pred_base = (r_state == ST_CHECK) ? r_exp_q : w_q_obs;

    contador_ref_model #(
        .WIDTH (WIDTH)
    ) u_ref_model (
        .i_q      (w_pred_base),
        .i_enable (enable),
        .i_mode   (mode),
        .i_d      (D),
        .o_q      (w_pred_q),
        .o_rco    (w_pred_rco),
        .o_load   (w_pred_load)
    );

    assign w_mismatch = (r_state == ST_CHECK) && r_exp_valid &&
                        ((w_q_obs != r_exp_q) || (rco != r_exp_rco) ||
                         (load != r_exp_load));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_WAIT_SYNC;
            r_exp_q      <= '0;
            r_exp_rco    <= 1'b0;
            r_exp_load   <= 1'b0;
            r_exp_valid  <= 1'b0;
            r_err        <= 1'b0;
            r_err_sticky <= 1'b0;
            r_err_count  <= '0;
            r_rco_count  <= '0;
        end else begin
            r_exp_q     <= w_pred_q;
            r_exp_rco   <= w_pred_rco;
            r_exp_load  <= w_pred_load;
            r_exp_valid <= 1'b1;
            r_err       <= w_mismatch;

            if (rco && (r_rco_count != '1)) begin
                r_rco_count <= r_rco_count + CNT_W'(1);
            end

            case (r_state)
                ST_WAIT_SYNC: begin
                    r_state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (w_mismatch) begin
                        r_state      <= ST_RESYNC;
                        r_err_sticky <= 1'b1;
                        if (r_err_count != '1) begin
                            r_err_count <= r_err_count + CNT_W'(1);
                        end
                    end
                end
                ST_RESYNC: begin
                    r_state <= ST_CHECK;
                end
                default: begin
                    r_state <= ST_WAIT_SYNC;
                end
            endcase
        end
    end

    assign synced     = (r_state != ST_WAIT_SYNC);
    assign err        = r_err;
    assign err_sticky = r_err_sticky;
    assign err_count  = r_err_count;
    assign rco_count  = r_rco_count;

`ifdef CONTADOR_MONITOR_FIRST_ERR_CAPTURE_EN
    logic [WIDTH-1:0] r_first_exp;
    logic [WIDTH-1:0] r_first_got;
    logic [31:0]      r_first_cycle;
    logic [31:0]      r_cycle;

    // The sticky flag doubles as the "already captured" marker.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_first_exp   <= '0;
            r_first_got   <= '0;
            r_first_cycle <= '0;
            r_cycle       <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_mismatch && !r_err_sticky) begin
                r_first_exp   <= r_exp_q;
                r_first_got   <= w_q_obs;
                r_first_cycle <= r_cycle;
            end
        end
    end

    assign first_err_exp   = r_first_exp;
    assign first_err_got   = r_first_got;
    assign first_err_cycle = r_first_cycle;
`endif

endmodule : contador_monitor

`default_nettype wire

// File: tb/tb_contador_monitor.sv
// ============================================================================
// Module   : tb_contador_monitor
// Brief    : Scoreboard bench: emulates the counter, injects faults and
//            predicts every monitor output from the counter contract.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_contador_monitor;

    localparam int      WIDTH = 32;
    localparam int      CNT_W = 5;
    localparam longint  MOD   = 64'h1_0000_0000;

    logic             clk;
    logic             reset;
    logic             enable;
    logic [1:0]       mode;
    logic [3:0]       D;
    logic             load;
    logic             rco;
    logic [0:WIDTH-1] Q;
    logic             synced;
    logic             err;
    logic             err_sticky;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] rco_count;
`ifdef CONTADOR_MONITOR_FIRST_ERR_CAPTURE_EN
    logic [WIDTH-1:0] first_err_exp;
    logic [WIDTH-1:0] first_err_got;
    logic [31:0]      first_err_cycle;
`endif

    contador_monitor #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .mode            (mode),
        .D               (D),
        .load            (load),
        .rco             (rco),
        .Q               (Q),
`ifdef CONTADOR_MONITOR_FIRST_ERR_CAPTURE_EN
        .first_err_exp   (first_err_exp),
        .first_err_got   (first_err_got),
        .first_err_cycle (first_err_cycle),
`endif
        .synced          (synced),
        .err             (err),
        .err_sticky      (err_sticky),
        .err_count       (err_count),
        .rco_count       (rco_count)
    );

    typedef struct packed {
        logic        synced;
        logic        err;
        logic        sticky;
        logic [31:0] ecount;
        logic [31:0] rcount;
        logic [31:0] fexp;
        logic [31:0] fgot;
        logic [31:0] fcyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Emulated counter: the response it currently presents.
    logic [31:0] cnt_q    = '0;
    logic        cnt_rco  = 1'b0;
    logic        cnt_load = 1'b0;

    // Monitor expectations, kept in terms of the checking rules.
    int          m_edges      = 0;
    logic        m_prev_err   = 1'b0;
    logic        m_pred_valid = 1'b0;
    logic [31:0] m_pred_q     = '0;
    logic        m_pred_rco   = 1'b0;
    logic        m_pred_load  = 1'b0;
    logic        m_sticky     = 1'b0;
    int          m_ecount     = 0;
    int          m_rcount     = 0;
    logic [31:0] m_fexp       = '0;
    logic [31:0] m_fgot       = '0;
    logic [31:0] m_fcyc       = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void next_count(input logic [31:0] q, input logic en,
                                       input logic [1:0] md, input logic [3:0] d,
                                       output logic [31:0] nq, output logic nrco,
                                       output logic nload);
        longint v;
        v     = longint'(q);
        nq    = q;
        nrco  = 1'b0;
        nload = 1'b0;
        if (en) begin
            case (md)
                2'b00: begin
                    nrco = (v == MOD - 1);
                    nq   = 32'((v + 1) % MOD);
                end
                2'b01: begin
                    nrco = (v == 0);
                    nq   = 32'((v + MOD - 1) % MOD);
                end
                2'b10: begin
                    nrco = (v < 3);
                    nq   = 32'((v + MOD - 3) % MOD);
                end
                default: begin
                    nq    = {28'd0, d};
                    nload = 1'b1;
                end
            endcase
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    endtask

    // One cycle: present the counter's current response plus new stimulus,
    // then record what the monitor must show after the coming edge.
    task automatic step(input logic rst_n, input logic en, input logic [1:0] md,
                        input logic [3:0] d, input logic [31:0] qx,
                        input logic frco, input logic fload);
        logic [31:0] obs_q;
        logic        obs_rco, obs_load, compare, mis;
        logic [31:0] base;
        exp_t        e;
        @(negedge clk);
        obs_q    = cnt_q ^ qx;
        obs_rco  = cnt_rco ^ frco;
        obs_load = cnt_load ^ fload;
        reset  = rst_n;
        enable = en;
        mode   = md;
        D      = d;
        Q      = obs_q;
        rco    = obs_rco;
        load   = obs_load;
        if (!rst_n) begin
            m_edges = 0; m_prev_err = 0; m_pred_valid = 0; m_pred_q = '0;
            m_pred_rco = 0; m_pred_load = 0; m_sticky = 0; m_ecount = 0;
            m_rcount = 0; m_fexp = '0; m_fgot = '0; m_fcyc = '0;
            cnt_q = '0; cnt_rco = 0; cnt_load = 0;
            e = '0;
        end else begin
            compare = (m_edges != 0) && !m_prev_err && m_pred_valid;
            mis = compare && ((obs_q != m_pred_q) || (obs_rco != m_pred_rco) ||
                              (obs_load != m_pred_load));
            if (mis && !m_sticky) begin
                m_fexp = m_pred_q;
                m_fgot = obs_q;
                m_fcyc = 32'(m_edges);
            end
            if (mis) begin
                m_sticky = 1'b1;
                if (m_ecount < (1 << CNT_W) - 1) m_ecount++;
            end
            if (obs_rco && m_rcount < (1 << CNT_W) - 1) m_rcount++;
            base = compare ? m_pred_q : obs_q;
            next_count(base, en, md, d, m_pred_q, m_pred_rco, m_pred_load);
            m_pred_valid = 1'b1;
            m_prev_err   = mis;
            m_edges++;
            next_count(cnt_q, en, md, d, cnt_q, cnt_rco, cnt_load);
            e = '{synced: 1'b1, err: mis, sticky: m_sticky, ecount: 32'(m_ecount),
                  rcount: 32'(m_rcount), fexp: m_fexp, fgot: m_fgot, fcyc: m_fcyc};
        end
        exp_q.push_back(e);
    endtask

    task automatic go(input logic en, input logic [1:0] md, input logic [3:0] d);
        step(1'b1, en, md, d, 32'd0, 1'b0, 1'b0);
    endtask

    // Monitor side of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("synced",     32'(synced),     32'(e.synced));
                chk("err",        32'(err),        32'(e.err));
                chk("err_sticky", 32'(err_sticky), 32'(e.sticky));
                chk("err_count",  32'(err_count),  e.ecount);
                chk("rco_count",  32'(rco_count),  e.rcount);
`ifdef CONTADOR_MONITOR_FIRST_ERR_CAPTURE_EN
                chk("first_err_exp",   first_err_exp,   e.fexp);
                chk("first_err_got",   first_err_got,   e.fgot);
                chk("first_err_cycle", first_err_cycle, e.fcyc);
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; enable = 1'b0; mode = 2'b00; D = 4'd0;
        load = 1'b0; rco = 1'b0; Q = '0;

        step(1'b0, 1'b0, 2'b00, 4'd0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 2'b00, 4'd0, 32'd0, 1'b0, 1'b0);
        repeat (51) go(1'b1, 2'b00, 4'd0);

        // Down wrap from 0, then up wrap back to 0.
        go(1'b1, 2'b11, 4'h0);
        go(1'b1, 2'b01, 4'h0);
        go(1'b1, 2'b00, 4'h0);
        go(1'b1, 2'b00, 4'h0);
        go(1'b1, 2'b00, 4'h0);

        // Borrow on down-by-3 from 2, with rco dropped by the counter.
        go(1'b1, 2'b11, 4'h2);
        go(1'b1, 2'b10, 4'h0);
        step(1'b1, 1'b1, 2'b00, 4'h0, 32'd0, 1'b1, 1'b0);
        repeat (4) go(1'b1, 2'b00, 4'h0);

        // Load 0xA, counter presents 0xB.
        go(1'b1, 2'b11, 4'hA);
        step(1'b1, 1'b1, 2'b10, 4'h0, 32'd1, 1'b0, 1'b0);
        repeat (3) go(1'b1, 2'b10, 4'h0);

        // Hold at 7 for ten cycles with one spurious load.
        go(1'b1, 2'b11, 4'h7);
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b0, 2'b00, 4'h0, 32'd0, 1'b0, (i == 5));
        go(1'b1, 2'b00, 4'h0);

        // Reset landing on a cycle that carries a mismatch.
        repeat (3) go(1'b1, 2'b00, 4'h0);
        step(1'b0, 1'b1, 2'b00, 4'h0, 32'h0000_0100, 1'b0, 1'b0);
        repeat (5) go(1'b1, 2'b00, 4'h0);

        for (int i = 0; i < 800; i++) begin
            logic        rst_n, en, frco, fload;
            logic [1:0]  md;
            logic [3:0]  d;
            logic [31:0] qx;
            int          f;
            rst_n = ($urandom_range(0, 99) >= 2);
            en    = ($urandom_range(0, 9) != 0);
            md    = 2'($urandom_range(0, 3));
            d     = 4'($urandom_range(0, 15));
            f     = $urandom_range(0, 99);
            qx    = (f < 3) ? (32'd1 << $urandom_range(0, 31)) : 32'd0;
            frco  = (f == 3 || f == 4);
            fload = (f == 5);
            step(rst_n, en, md, d, qx, frco, fload);
        end

        @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_contador_monitor

`default_nettype wire
